// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the RAW hazard scoreboard
package hazard_pkg;

    // Widest register index any instance may use; entries store rd at this width
    localparam int REG_W_MAX = 8;

    // Forward-select value meaning "read the register file"
    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic                 v;
        logic [REG_W_MAX-1:0] rd;
        logic                 ld;
    } sb_entry_t;

    // Select field width: enough for stage numbers 1..depth-1, never zero bits
    function automatic int sel_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode-side bundle between decode and the scoreboard
interface hazard_scoreboard_if #(
    parameter int REG_W = 3,
    parameter int SEL_W = 2,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_rs_used;
    logic             id_rt_used;
    logic             id_wr_en;
    logic [REG_W-1:0] id_rd;
    logic             id_is_load;
    logic             flush;
    logic             stall;
    logic             issue;
    logic [SEL_W-1:0] fwd_rs_sel;
    logic [SEL_W-1:0] fwd_rt_sel;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_wr_en, id_rd, id_is_load, flush,
        input  stall, issue, fwd_rs_sel, fwd_rt_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_wr_en, id_rd, id_is_load, flush,
        output stall, issue, fwd_rs_sel, fwd_rt_sel, stall_cnt
    );
endinterface

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - per-source priority matcher over in-flight stages
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_W  = 3,
    parameter int DEPTH  = 3,
    parameter int FWD_EN = 0,
    parameter int LD_LAT = 1,
    parameter int SEL_W  = 2
) (
    input  sb_entry_t        stages [1:DEPTH],
    input  logic [REG_W-1:0] src,
    input  logic             used,
    output logic             hazard,
    output logic [SEL_W-1:0] sel
);

    // Youngest matching writer wins; the last stage is covered by the regfile bypass
    always_comb begin
        logic found;
        found  = 1'b0;
        hazard = 1'b0;
        sel    = SEL_W'(FWD_REGFILE);
        for (int k = 1; k <= DEPTH - 1; k++) begin
            if (!found && used && stages[k].v && (stages[k].rd[REG_W-1:0] == src)) begin
                found = 1'b1;
                if (FWD_EN == 0) begin
                    hazard = 1'b1;
                end else if (stages[k].ld && (k <= LD_LAT)) begin
                    hazard = 1'b1;
                end else begin
                    sel = SEL_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RAW hazard scoreboard with optional forwarding and flush
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W        = 3,
    parameter int DEPTH        = 3,
    parameter int FWD_EN       = 0,
    parameter int LD_LAT       = 1,
    parameter int FLUSH_STAGES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  bus
);

    localparam int SEL_W = sel_w(DEPTH);

    sb_entry_t        stages [1:DEPTH];
    sb_entry_t        new_entry;
    logic             haz_rs;
    logic             haz_rt;
    logic             hazard;
    logic [SEL_W-1:0] sel_rs;
    logic [SEL_W-1:0] sel_rt;
    logic [CNT_W-1:0] cnt;

    hazard_match #(
        .REG_W(REG_W), .DEPTH(DEPTH), .FWD_EN(FWD_EN), .LD_LAT(LD_LAT), .SEL_W(SEL_W)
    ) u_match_rs (
        .stages(stages), .src(bus.id_rs), .used(bus.id_rs_used),
        .hazard(haz_rs), .sel(sel_rs)
    );

    hazard_match #(
        .REG_W(REG_W), .DEPTH(DEPTH), .FWD_EN(FWD_EN), .LD_LAT(LD_LAT), .SEL_W(SEL_W)
    ) u_match_rt (
        .stages(stages), .src(bus.id_rt), .used(bus.id_rt_used),
        .hazard(haz_rt), .sel(sel_rt)
    );

    assign hazard         = haz_rs | haz_rt;
    assign bus.stall      = bus.id_valid & hazard & ~bus.flush;
    assign bus.issue      = bus.id_valid & ~hazard & ~bus.flush;
    assign bus.fwd_rs_sel = sel_rs;
    assign bus.fwd_rt_sel = sel_rt;
    assign bus.stall_cnt  = cnt;

    // Entry presented to stage 1; only meaningful when the instruction issues
    always_comb begin
        new_entry    = '0;
        new_entry.v  = bus.id_wr_en;
        new_entry.rd = REG_W_MAX'(bus.id_rd);
        new_entry.ld = bus.id_is_load;
    end

    // Advance the in-flight pipe; flush turns young entries into bubbles as they move
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) begin
                stages[k] <= '0;
            end
        end else begin
            stages[1] <= bus.issue ? new_entry : '0;
            for (int k = 2; k <= DEPTH; k++) begin
                if (bus.flush && ((k - 1) < FLUSH_STAGES)) begin
                    stages[k] <= '0;
                end else begin
                    stages[k] <= stages[k-1];
                end
            end
        end
    end

    // Saturating count of cycles spent stalling decode
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (bus.stall && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized bench for hazard_scoreboard against an issue-history model
module tb_hazard_scoreboard;

    localparam int DEPTH = 3;
    localparam int N     = 2400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [2:0] id_rs = '0;
    logic [2:0] id_rt = '0;
    logic       id_rs_used = 1'b0;
    logic       id_rt_used = 1'b0;
    logic       id_wr_en = 1'b0;
    logic [2:0] id_rd = '0;
    logic       id_is_load = 1'b0;
    logic       flush = 1'b0;

    hazard_scoreboard_if #(.REG_W(3), .SEL_W(2), .CNT_W(4))  b0 ();
    hazard_scoreboard_if #(.REG_W(3), .SEL_W(2), .CNT_W(16)) b1 ();

    assign b0.id_valid = id_valid;   assign b1.id_valid = id_valid;
    assign b0.id_rs = id_rs;         assign b1.id_rs = id_rs;
    assign b0.id_rt = id_rt;         assign b1.id_rt = id_rt;
    assign b0.id_rs_used = id_rs_used; assign b1.id_rs_used = id_rs_used;
    assign b0.id_rt_used = id_rt_used; assign b1.id_rt_used = id_rt_used;
    assign b0.id_wr_en = id_wr_en;   assign b1.id_wr_en = id_wr_en;
    assign b0.id_rd = id_rd;         assign b1.id_rd = id_rd;
    assign b0.id_is_load = id_is_load; assign b1.id_is_load = id_is_load;
    assign b0.flush = flush;         assign b1.flush = flush;

    hazard_scoreboard #(.REG_W(3), .DEPTH(DEPTH), .FWD_EN(0), .LD_LAT(1),
                        .FLUSH_STAGES(1), .CNT_W(4)) u0 (.clk(clk), .rst(rst), .bus(b0));
    hazard_scoreboard #(.REG_W(3), .DEPTH(DEPTH), .FWD_EN(1), .LD_LAT(1),
                        .FLUSH_STAGES(2), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    // model configuration per instance
    int m_fwd   [2] = '{0, 1};
    int m_fs    [2] = '{1, 2};
    int m_ldlat [2] = '{1, 1};
    int m_max   [2] = '{15, 65535};

    // per-cycle history: what issued and what control events happened
    bit       h_iss [2][N];
    bit       h_wr  [N];
    bit       h_ld  [N];
    bit       h_fl  [N];
    bit       h_rst [N];
    bit [2:0] h_rd  [N];
    int       t = 0;
    int       m_cnt [2] = '{0, 0};

    int o_stall [2];
    int o_issue [2];
    int o_rs    [2];
    int o_rt    [2];
    int o_cnt   [2];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d: got %0d expected %0d", name, t, act, exp);
        end
    endtask

    // The writer issued k cycles ago is visible unless a reset or an early flush killed it
    function automatic void model_src(input int i, input logic [2:0] src, input bit used,
                                      output bit haz, output int sel);
        haz = 1'b0;
        sel = 0;
        if (!used) return;
        for (int k = 1; k <= DEPTH - 1; k++) begin
            int  c;
            bit  live;
            c = t - k;
            if (c < 0) break;
            live = h_iss[i][c] && h_wr[c];
            for (int r = c; r < t; r++) if (h_rst[r]) live = 1'b0;
            for (int f = c + 1; f <= c + m_fs[i] - 1 && f < t; f++) if (h_fl[f]) live = 1'b0;
            if (live && h_rd[c] == src) begin
                if (m_fwd[i] == 0) haz = 1'b1;
                else if (h_ld[c] && k <= m_ldlat[i]) haz = 1'b1;
                else sel = k;
                return;
            end
        end
    endfunction

    task automatic step(input bit v, input int rs, input int rt, input bit rsu, input bit rtu,
                        input bit wr, input int rd, input bit ld, input bit fl, input bit r);
        bit hz_s, hz_t;
        int sl_s, sl_t;
        bit ms, mi;
        id_valid = v; id_rs = 3'(rs); id_rt = 3'(rt); id_rs_used = rsu; id_rt_used = rtu;
        id_wr_en = wr; id_rd = 3'(rd); id_is_load = ld; flush = fl; rst = r;
        @(negedge clk);
        o_stall[0] = int'(b0.stall);  o_stall[1] = int'(b1.stall);
        o_issue[0] = int'(b0.issue);  o_issue[1] = int'(b1.issue);
        o_rs[0] = int'(b0.fwd_rs_sel); o_rs[1] = int'(b1.fwd_rs_sel);
        o_rt[0] = int'(b0.fwd_rt_sel); o_rt[1] = int'(b1.fwd_rt_sel);
        o_cnt[0] = int'(b0.stall_cnt); o_cnt[1] = int'(b1.stall_cnt);
        h_wr[t] = wr; h_ld[t] = ld; h_fl[t] = fl; h_rst[t] = r; h_rd[t] = 3'(rd);
        for (int i = 0; i < 2; i++) begin
            model_src(i, 3'(rs), rsu, hz_s, sl_s);
            model_src(i, 3'(rt), rtu, hz_t, sl_t);
            ms = v && (hz_s || hz_t) && !fl;
            mi = v && !(hz_s || hz_t) && !fl;
            chk($sformatf("stall[%0d]", i), o_stall[i], int'(ms));
            chk($sformatf("issue[%0d]", i), o_issue[i], int'(mi));
            chk($sformatf("stall_cnt[%0d]", i), o_cnt[i], m_cnt[i]);
            if (v) begin
                chk($sformatf("fwd_rs_sel[%0d]", i), o_rs[i], hz_s ? 0 : sl_s);
                chk($sformatf("fwd_rt_sel[%0d]", i), o_rt[i], hz_t ? 0 : sl_t);
            end
            h_iss[i][t] = mi;
            if (r) m_cnt[i] = 0;
            else if (ms && m_cnt[i] < m_max[i]) m_cnt[i]++;
        end
        t++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int cnt_before;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        chk("rst_stall0", o_stall[0], 0);
        chk("rst_cnt0", o_cnt[0], 0);

        // writer r3, then a dependent reader
        step(1, 1, 2, 1, 1, 1, 3, 0, 0, 0);
        chk("t1_issue0", o_issue[0], 1);
        step(1, 3, 0, 1, 0, 1, 6, 0, 0, 0);
        chk("t1_stall0_a", o_stall[0], 1);
        chk("t2_stall1", o_stall[1], 0);
        chk("t2_sel1", o_rs[1], 1);
        step(1, 3, 0, 1, 0, 1, 6, 0, 0, 0);
        chk("t1_stall0_b", o_stall[0], 1);
        chk("t2_sel2", o_rs[1], 2);
        step(1, 3, 0, 1, 0, 1, 6, 0, 0, 0);
        chk("t1_issue0_c", o_issue[0], 1);
        chk("t1_cnt0", o_cnt[0], 2);
        idle(3);

        // load-use
        step(1, 1, 0, 1, 0, 1, 4, 1, 0, 0);
        step(1, 0, 4, 0, 1, 1, 7, 0, 0, 0);
        chk("t3_stall1", o_stall[1], 1);
        step(1, 0, 4, 0, 1, 1, 7, 0, 0, 0);
        chk("t3_issue1", o_issue[1], 1);
        chk("t3_rtsel1", o_rt[1], 2);
        idle(3);

        // youngest writer wins; unused source never forwards
        step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        step(1, 5, 0, 1, 0, 1, 1, 0, 0, 0);
        chk("t4_young", o_rs[1], 1);
        step(1, 5, 0, 0, 0, 1, 1, 0, 0, 0);
        chk("t4_unused_sel", o_rs[1], 0);
        chk("t4_unused_stall", o_stall[1], 0);
        idle(3);

        // flush overrides hazard and squashes young entries
        step(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        step(1, 3, 2, 1, 1, 1, 1, 0, 1, 0);
        chk("t5_stall0", o_stall[0], 0);
        chk("t5_issue0", o_issue[0], 0);
        chk("t5_issue1", o_issue[1], 0);
        cnt_before = o_cnt[0];
        step(1, 3, 2, 1, 1, 1, 1, 0, 0, 0);
        chk("t5_cnt_hold", o_cnt[0], cnt_before);
        chk("t5_stall0_after", o_stall[0], 1);
        chk("t5_stall1_after", o_stall[1], 0);
        chk("t5_rssel1", o_rs[1], 0);
        chk("t5_rtsel1", o_rt[1], 0);

        // reset mid-stall
        step(1, 3, 2, 1, 1, 1, 1, 0, 0, 1);
        step(1, 3, 2, 1, 1, 1, 1, 0, 0, 0);
        chk("t6_stall0", o_stall[0], 0);
        chk("t6_cnt0", o_cnt[0], 0);

        // self-dependent stream drives the 4-bit counter into saturation
        for (int j = 0; j < 40; j++) step(1, 1, 0, 1, 0, 1, 1, 0, 0, 0);
        chk("t6_sat", o_cnt[0], 15);
        chk("t6_fwd_nostall", o_stall[1], 0);

        // randomized traffic
        for (int j = 0; j < 2000; j++) begin
            step($urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                 $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised RAW-hazard scoreboard for the in-order 16-bit pipeline. It sits beside decode.
- Tracks in-flight destination registers over DEPTH post-decode stages and asserts stall (bubble insertion) against the decoding instruction.
- Optionally produces forwarding selects, with load-use stalls, instead of always stalling to writeback.
- Adds flush and a saturating stall-cycle counter.

Parameters:
REG_W, 3, register index width (2**REG_W architectural registers, no hardwired zero)
DEPTH, 3, stages from issue to regfile write; stage DEPTH writes the regfile at the end of its cycle
FWD_EN, 0, 0 = stall until writeback; 1 = forward from stages 1..DEPTH-1
LD_LAT, 1, with FWD_EN=1: a load result is not forwardable while the load sits in stages 1..LD_LAT
FLUSH_STAGES, 1, flush kills the issuing instruction plus entries in stages 1..FLUSH_STAGES-1
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
id_valid  input  1  decode holds a valid instruction
id_rs  input  REG_W  source 1 index
id_rt  input  REG_W  source 2 index
id_rs_used  input  1  source 1 is read
id_rt_used  input  1  source 2 is read
id_wr_en  input  1  instruction writes a register
id_rd  input  REG_W  destination index
id_is_load  input  1  instruction is a memory load
flush  input  1  control-flow squash
stall  output  1  hold decode and insert a bubble
issue  output  1  instruction advances this cycle
fwd_rs_sel  output  $clog2(DEPTH)  0 = regfile, k = forward from stage k
fwd_rt_sel  output  $clog2(DEPTH)  same encoding for source 2
stall_cnt  output  CNT_W  saturating count of stall cycles

Behaviour:
- Clock and reset: one clock, clk; rst synchronous, active-high.
- Reset: all entries invalid, stall_cnt=0. Combinational outputs therefore read stall=0, fwd_*_sel=0 in the first cycle after reset. rst mid-operation discards all in-flight entries.
- Entry state: stage[k], k=1..DEPTH, holds {v, rd, ld}.
- Shift each edge: stage[k+1] <= stage[k]; stage[DEPTH] retires.
- Stage 1 load: stage[1] <= {id_wr_en, id_rd, id_is_load} when issue, else a bubble (v=0).
- Match: match_s[k] = stage[k].v & (stage[k].rd == src) & src_used, for k=1..DEPTH-1. Stage DEPTH never matches; the regfile's write-before-read bypass covers it.
- FWD_EN=0: hazard = any match on rs or rt. Both fwd_*_sel stay 0.
- FWD_EN=1: per source, k* = smallest matching k (youngest writer wins).
  - hazard if stage[k*].ld and k* <= LD_LAT.
  - fwd_sel = k* if no hazard, else 0; fwd_sel = 0 if no match.
- stall = id_valid & hazard & ~flush.
- issue = id_valid & ~hazard & ~flush.
- Flush: stage[1] gets a bubble. Entries leaving stages 1..FLUSH_STAGES-1 enter the next stage as bubbles. Flush overrides hazard: stall=0, issue=0.
- stall_cnt: increments on each cycle with stall=1; holds at 2**CNT_W-1.
- A writer and reader in the same cycle cannot conflict; the scoreboard only sees already-issued entries.
- Latency: decision is combinational from registered state plus id_* inputs; entry update takes 1 cycle.
- No X on outputs when id_valid=0: stall=0, issue=0, selects still computed but don't-care.

Decomposition:
- Package hazard_pkg:
  - sb_entry_t typedef {v, rd, ld}
  - FWD_REGFILE=0 constant
  - width function for the select field
- One sub-module hazard_match: per-source priority matcher over stages 1..DEPTH-1, returning the hazard bit and k*. It is instantiated twice (rs, rt).
- Shift register and counter live in the top.

Test Plan:
1. FWD_EN=0, DEPTH=3: issue ADD wr r3; next cycle decode reads rs=r3 -> stall=1 for 2 cycles, issue=1 on the 3rd, stall_cnt=2.
2. FWD_EN=1: ADD wr r3 then consumer rs=r3 -> stall=0, fwd_rs_sel=1. With one independent instruction between -> fwd_rs_sel=2.
3. FWD_EN=1, LD_LAT=1: LD r4 then consumer rt=r4 -> stall=1 for one cycle, then issue=1 with fwd_rt_sel=2.
4. FWD_EN=1: writers to r5 sit in stages 1 and 2 -> fwd_rs_sel=1. Reader with rs_used=0 -> fwd_rs_sel=0, stall=0.
5. Hazard present and flush=1 -> stall=0, issue=0, stall_cnt unchanged, stage[1] invalid next cycle. FLUSH_STAGES=2 additionally squashes the old stage-1 entry.
6. rst asserted with 2 valid entries and stall=1 -> next cycle stall=0, stall_cnt=0. Forcing CNT_W=4 with 20 stall cycles -> stall_cnt holds at 15.
